// File: rtl/bcd_counter_n.sv
// Parameterised multi-digit BCD up/down counter with parallel load, terminal count and sticky ovf.
// Define BCD_COUNTER_SAT_EN to saturate at the ends instead of trapping into the error pattern.
module bcd_counter_n #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  count_clear,
    input  logic                  count_ena,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] ErrPat = {DIGITS{4'hE}};

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] inc_val, dec_val;
    logic         ovf_q, ovf_d;
    logic         err, all9, all0, load_bad;
    logic         carry, borrow;

    // err is defined by the count contents, so it can never disagree with them.
    assign err = (count_q == ErrPat);

    always_comb begin
        all9     = 1'b1;
        all0     = 1'b1;
        load_bad = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (count_q[4*k +: 4] != 4'd9) all9 = 1'b0;
            if (count_q[4*k +: 4] != 4'd0) all0 = 1'b0;
            if (load_val[4*k +: 4] > 4'd9) load_bad = 1'b1;
        end
    end

    always_comb begin
        inc_val = count_q;
        dec_val = count_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (load) begin
            if (load_bad) begin
                count_d = ErrPat;
                ovf_d   = 1'b1;
            end else begin
                count_d = load_val;
                ovf_d   = 1'b0;
            end
        end else if (count_ena && !err) begin
            if ((up_down && all9) || (!up_down && all0)) begin
                ovf_d = 1'b1;
`ifdef BCD_COUNTER_SAT_EN
                count_d = count_q;
`else
                count_d = ErrPat;
`endif
            end else if (up_down) begin
                count_d = inc_val;
            end else begin
                count_d = dec_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (count_clear) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = count_ena & ~err & ((up_down & all9) | (~up_down & all0));

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits; legal range 1..8.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 count_clear  in  1  reset, synchronous, active-high.
REQ-004 count_ena  in  1  count enable; one step per clock while high.
REQ-005 up_down  in  1  direction: 1 = increment, 0 = decrement.
REQ-006 load  in  1  synchronous parallel load strobe.
REQ-007 load_val  in  4*DIGITS  load value; digit k at bits [4k+3:4k].
REQ-008 count  out  4*DIGITS  registered count; digit 0 least significant.
REQ-009 tc  out  1  terminal count, combinational: count_ena & ~err & ((up_down & all digits 9) | (~up_down & all digits 0)).
REQ-010 ovf  out  1  registered, sticky overflow/underflow/error flag.

Function
REQ-011 Priority per edge SHALL be: count_clear > load > count_ena; otherwise hold.
REQ-012 Count SHALL change on the edge that samples count_ena high; the new value is visible one cycle later, with no extra pipeline delay.
REQ-013 Increment: digit 0 +1; a digit at 9 SHALL wrap to 0 and carry into the next digit in the same cycle; full ripple across all DIGITS.
REQ-014 Decrement: digit 0 -1; a digit at 0 SHALL wrap to 9 and borrow from the next digit in the same cycle.
REQ-015 Load: each load_val digit <=9 SHALL be copied to count and ovf cleared; if any digit >9, count SHALL take the error pattern and ovf SHALL set to 1.
REQ-016 Error pattern SHALL be 4'hE in every digit; internal err state is 1 whenever count holds the error pattern.
REQ-017 In err, count_ena SHALL be ignored; only count_clear or a valid load leaves err.
REQ-018 Increment at all-9s (tc=1) SHALL produce the overflow response of REQ-026/REQ-027; decrement at all-0s SHALL produce the underflow response of the same requirements.
REQ-019 ovf, once set, SHALL remain 1 until count_clear or a valid load.
REQ-020 load asserted together with count_ena SHALL load only; no step is applied that cycle.
REQ-021 up_down SHALL be sampled only on edges where a step occurs; changing it mid-run takes effect on the next step.
REQ-022 No internal digit value other than 0..9 or 4'hE SHALL ever be reachable.

Reset
REQ-023 count_clear high at an edge SHALL set count to all zeros, ovf to 0 and err to 0, overriding load and count_ena.
REQ-024 Reset SHALL take effect only at a clock edge; there is no asynchronous path.
REQ-025 Reset asserted during the cycle an overflow would occur SHALL yield zeros with ovf=0.

Configuration
REQ-026 With macro BCD_COUNTER_SAT_EN undefined: overflow and underflow SHALL load the error pattern (REQ-016), set ovf=1 and enter err.
REQ-027 With BCD_COUNTER_SAT_EN defined: overflow SHALL hold all-9s and underflow SHALL hold all-0s, set ovf=1, and not enter err; counting in the opposite direction SHALL resume normally while ovf stays sticky.

Verification (DIGITS=4 unless stated)
REQ-028 Clear, then count_ena=1, up_down=1 for 1234 cycles -> count=16'h1234, ovf=0.
REQ-029 Load 16'h9999, up step -> tc=1 before the edge; macro off: count=16'hEEEE, ovf=1, and further steps hold 16'hEEEE; macro on: count=16'h9999, ovf=1.
REQ-030 Load 16'h0100, down step -> 16'h0099; load 16'h0000, down step -> macro off: 16'hEEEE, ovf=1; macro on: 16'h0000, ovf=1.
REQ-031 Load 16'h12A4 -> count=16'hEEEE, ovf=1; then load 16'h0042 -> count=16'h0042, ovf=0.
REQ-032 load=1 with load_val 16'h0500, count_ena=1 and count_clear=1 in the same cycle -> count=16'h0000, ovf=0; same without count_clear -> count=16'h0500.
REQ-033 DIGITS=1: 10 up steps from 0 -> 4'hE with ovf=1 (macro off), or 4'h9 with ovf=1 (macro on).
